ub_read_streamer: RTL

UB_READ_STREAMER -- requirements
Module: ub_read_streamer

---
 rtl/ub_read_streamer_pkg.sv | 14 +
 rtl/ub_stream_fifo.sv | 49 ++++
 rtl/ub_read_streamer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/ub_read_streamer_pkg.sv
// Shared definitions for the unified-buffer read path: FSM states and UB address/count widths.
package ub_read_streamer_pkg;

  localparam int UB_ADDR_WIDTH = 8;
  // Word address plus one bank-select MSB; counts use the same width.
  localparam int UB_AW = UB_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

endpackage

// File: rtl/ub_stream_fifo.sv
// Output FIFO for the UB read streamer: registered write, combinational head, push/pop/count.
module ub_stream_fifo #(
  parameter int WIDTH = 257,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; the count alone decides validity, so a reset only needs the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ub_read_streamer.sv
// Splits a read command into UB bursts of at most MAX_BURST words and streams the words out.
module ub_read_streamer
  import ub_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = UB_ADDR_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH:0]   cmd_addr,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  output logic                  ub_rd_en,
  output logic [ADDR_WIDTH:0]   ub_rd_addr,
  output logic [ADDR_WIDTH:0]   ub_rd_count,
  input  logic [DATA_WIDTH-1:0] ub_rd_data,
  input  logic                  ub_rd_valid,
  input  logic                  ub_busy,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int AW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_e        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] remaining;
  logic [AW-1:0] beat_cnt;
  logic [AW-1:0] chunk;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] free_entries;
  logic          fifo_empty;
  logic          issue;
  logic          beat_accept;
  logic          beat_final;
  logic          cmd_last;

  // NOTE: default assignment first so no path through always_comb leaves chunk unassigned (no latch).
  always_comb begin
    chunk = remaining;
    if (remaining > AW'(MAX_BURST)) chunk = AW'(MAX_BURST);
  end

  // The UB cannot stall its beats, so a burst is only launched once the FIFO can absorb all of it.
  assign free_entries = CW'(FIFO_DEPTH) - fifo_count;
  assign issue        = (state == REQ) && !ub_busy && (32'(free_entries) >= 32'(chunk));
  assign beat_accept  = (state == WAIT) && ub_rd_valid && (beat_cnt < chunk);
  assign beat_final   = beat_accept && (beat_cnt == chunk - AW'(1));
  assign cmd_last     = beat_final && (remaining == chunk);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == '0) begin
              err <= 1'b1;
            end else begin
              addr      <= cmd_addr;
              remaining <= cmd_len;
              beat_cnt  <= '0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          if (issue) begin
            beat_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (beat_final) begin
            addr      <= addr + chunk;
            remaining <= remaining - chunk;
            beat_cnt  <= '0;
            state     <= (remaining == chunk) ? IDLE : REQ;
          end else if (beat_accept) begin
            beat_cnt <= beat_cnt + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ub_stream_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (beat_accept),
    .push_data ({cmd_last, ub_rd_data}),
    .pop       (m_valid && m_ready),
    .head      ({m_last, m_data}),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_ready   = (state == IDLE);
  assign ub_rd_en    = issue;
  assign ub_rd_addr  = addr;
  assign ub_rd_count = chunk;
  assign m_valid     = !fifo_empty;
  assign done        = m_valid && m_ready && m_last;
  assign busy        = (state != IDLE) || !fifo_empty;

endmodule
